// File: rtl/fetch_unit_if.sv
// Fetch unit connections: byte-wide instruction memory port, instruction
// stream to the consumer, and the redirect path from branch resolution.
interface fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] INSTRUCTION;
    logic [31:0] ins_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    // master is the fetch unit itself; slave is memory plus consumer side.
    modport master (
        output mem_req, mem_addr, ins_valid, INSTRUCTION, ins_pc,
        input  mem_ack, mem_rdata, ins_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, ins_valid, INSTRUCTION, ins_pc,
        output mem_ack, mem_rdata, ins_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: assembles big-endian 32-bit words from a byte
// memory and queues them with their PCs in a small prefetch FIFO.
module fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic          CLK,
    input  logic          RESET,
    fetch_unit_if.master  bus
);

    typedef enum logic {IDLE, FETCH} state_t;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    state_t             state;
    logic [1:0]         byte_idx;
    logic [31:0]        fetch_pc;
    logic [23:0]        word_hi;
    logic [31:0]        fifo_word [DEPTH];
    logic [31:0]        fifo_pc   [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    logic               push;
    logic               pop;
    logic [31:0]        redirect_aligned;

    assign push             = (state == FETCH) && bus.mem_ack && (byte_idx == 2'd3);
    assign pop              = bus.ins_valid && bus.ins_ready;
    assign redirect_aligned = bus.redirect_pc & 32'hFFFF_FFFC;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: FIFO storage carries no reset; count gates visibility, so stale
    // entries are never observed and the array can map onto plain registers/RAM.
    always_ff @(posedge CLK) begin
        if (push && !RESET && !bus.redirect) begin
            fifo_word[wr_ptr] <= {word_hi, bus.mem_rdata};
            fifo_pc[wr_ptr]   <= fetch_pc;
        end
    end

    // NOTE: all state is written with non-blocking assignments so every
    // branch below reads the pre-edge values of its sibling registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            byte_idx <= 2'd0;
            fetch_pc <= RESET_PC;
            word_hi  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (bus.redirect) begin
            // Redirect drops the queue, the partial word and any same-cycle ack.
            state    <= IDLE;
            byte_idx <= 2'd0;
            fetch_pc <= redirect_aligned;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase

            case (state)
                IDLE: begin
                    // A word is only started with a guaranteed free slot.
                    if (count < CNT_W'(DEPTH)) state <= FETCH;
                end
                FETCH: begin
                    if (bus.mem_ack) begin
                        case (byte_idx)
                            2'd0:    word_hi[23:16] <= bus.mem_rdata;
                            2'd1:    word_hi[15:8]  <= bus.mem_rdata;
                            2'd2:    word_hi[7:0]   <= bus.mem_rdata;
                            default: ;
                        endcase
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            fetch_pc <= fetch_pc + 32'd4;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req     = (state == FETCH);
    assign bus.mem_addr    = (state == FETCH) ? fetch_pc + {30'd0, byte_idx} : 32'd0;
    assign bus.ins_valid   = (count != '0);
    assign bus.INSTRUCTION = bus.ins_valid ? fifo_word[rd_ptr] : 32'd0;
    assign bus.ins_pc      = bus.ins_valid ? fifo_pc[rd_ptr]   : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: byte memory responder with programmable
// wait states, and one task per scenario with hand-computed expectations.
module tb_fetch_unit;

    logic CLK = 1'b0;
    logic RESET = 1'b1;

    int n_vec = 0;
    int n_err = 0;
    int wait_states = 0;
    int wait_cnt = 0;

    fetch_unit_if bus();

    fetch_unit #(.DEPTH(2), .RESET_PC(32'h0)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Bytes 0..3 are fixed; elsewhere a byte is its low address byte + 0x40.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h00;
            32'd1:   return 8'h01;
            32'd2:   return 8'h10;
            32'd3:   return 8'h20;
            default: return a[7:0] + 8'h40;
        endcase
    endfunction

    // Responder updates shortly after each rising edge; checks sample on the falling edge.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        forever begin
            @(posedge CLK);
            #2;
            if (bus.mem_req === 1'b1) begin
                if (wait_cnt >= wait_states) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_byte(bus.mem_addr);
                    wait_cnt      = 0;
                end else begin
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = 8'h00;
                    wait_cnt++;
                end
            end else begin
                bus.mem_ack = 1'b0;
                wait_cnt    = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic apply_reset();
        @(negedge CLK);
        RESET        = 1'b1;
        bus.redirect = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge CLK);
            if (bus.ins_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RESET        = 1'b1;
        bus.redirect = 1'b0;
        bus.ins_ready = 1'b1;
        repeat (3) @(negedge CLK);
        n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b, expected 0", bus.mem_req); end
        n_vec++; if (bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h, expected 00000000", bus.mem_addr); end
        n_vec++; if (bus.ins_valid !== 1'b0) begin n_err++; $display("FAIL reset_ins_valid: got %b, expected 0", bus.ins_valid); end
        n_vec++; if (bus.INSTRUCTION !== 32'h0) begin n_err++; $display("FAIL reset_instruction: got %h, expected 00000000", bus.INSTRUCTION); end
        n_vec++; if (bus.ins_pc !== 32'h0) begin n_err++; $display("FAIL reset_ins_pc: got %h, expected 00000000", bus.ins_pc); end
        RESET = 1'b0;
    endtask

    task automatic test_basic();
        int cyc;
        bit found;
        wait_states   = 0;
        bus.ins_ready = 1'b1;
        apply_reset();
        cyc   = 0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            cyc++;
            if (bus.mem_ack === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_vec++; if (!found || cyc != 1) begin n_err++; $display("FAIL basic_first_ack_cycle: got %0d (found=%0b), expected 1", cyc, found); end
        n_vec++; if (bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL basic_first_addr: got %h, expected 00000000", bus.mem_addr); end
        repeat (3) @(negedge CLK);
        n_vec++; if (bus.ins_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_early: got %b, expected 0", bus.ins_valid); end
        @(negedge CLK);
        n_vec++; if (bus.ins_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid_t4: got %b, expected 1", bus.ins_valid); end
        n_vec++; if (bus.INSTRUCTION !== 32'h0001_1020) begin n_err++; $display("FAIL basic_instruction: got %h, expected 00011020", bus.INSTRUCTION); end
        n_vec++; if (bus.ins_pc !== 32'h0) begin n_err++; $display("FAIL basic_ins_pc: got %h, expected 00000000", bus.ins_pc); end
        @(negedge CLK);
        n_vec++; if (bus.ins_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_one_cycle: got %b, expected 0", bus.ins_valid); end
    endtask

    task automatic test_backpressure();
        wait_states   = 0;
        bus.ins_ready = 1'b0;
        apply_reset();
        repeat (20) @(negedge CLK);
        n_vec++; if (bus.ins_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b, expected 1", bus.ins_valid); end
        n_vec++; if (bus.ins_pc !== 32'h0) begin n_err++; $display("FAIL bp_head_pc: got %h, expected 00000000", bus.ins_pc); end
        n_vec++; if (bus.INSTRUCTION !== 32'h0001_1020) begin n_err++; $display("FAIL bp_head_word: got %h, expected 00011020", bus.INSTRUCTION); end
        n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL bp_full_mem_req: got %b, expected 0", bus.mem_req); end
        bus.ins_ready = 1'b1;
        @(negedge CLK);
        n_vec++; if (bus.ins_pc !== 32'h4) begin n_err++; $display("FAIL bp_second_pc: got %h, expected 00000004", bus.ins_pc); end
        n_vec++; if (bus.INSTRUCTION !== 32'h4445_4647) begin n_err++; $display("FAIL bp_second_word: got %h, expected 44454647", bus.INSTRUCTION); end
        @(negedge CLK);
        n_vec++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h8) begin n_err++; $display("FAIL bp_resume_addr: got req=%b addr=%h, expected req=1 addr=00000008", bus.mem_req, bus.mem_addr); end
    endtask

    task automatic test_wait_states();
        bit          got;
        bit          prev_req;
        bit          prev_ack;
        logic [31:0] prev_addr;
        int          req_cycles;
        int          unstable;
        wait_states   = 3;
        bus.ins_ready = 1'b0;
        apply_reset();
        got        = 1'b0;
        prev_req   = 1'b0;
        prev_ack   = 1'b0;
        prev_addr  = 32'h0;
        req_cycles = 0;
        unstable   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (bus.ins_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (bus.mem_req === 1'b1) begin
                req_cycles++;
                if (prev_req && !prev_ack && bus.mem_addr !== prev_addr) unstable++;
            end
            prev_req  = bus.mem_req;
            prev_ack  = bus.mem_ack;
            prev_addr = bus.mem_addr;
        end
        n_vec++; if (!got) begin n_err++; $display("FAIL ws_timeout: got no ins_valid in 40 cycles, expected a word"); end
        n_vec++; if (unstable != 0) begin n_err++; $display("FAIL ws_addr_stable: got %0d address changes during waits, expected 0", unstable); end
        n_vec++; if (req_cycles != 16) begin n_err++; $display("FAIL ws_req_cycles: got %0d, expected 16", req_cycles); end
        n_vec++; if (bus.INSTRUCTION !== 32'h0001_1020) begin n_err++; $display("FAIL ws_word: got %h, expected 00011020", bus.INSTRUCTION); end
        n_vec++; if (bus.ins_pc !== 32'h0) begin n_err++; $display("FAIL ws_pc: got %h, expected 00000000", bus.ins_pc); end
        wait_states = 0;
    endtask

    task automatic test_redirect();
        bit found;
        bit ok;
        wait_states   = 0;
        bus.ins_ready = 1'b1;
        apply_reset();
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (bus.mem_req === 1'b1 && bus.mem_addr === 32'hA) begin
                found = 1'b1;
                break;
            end
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL redir_reach_byte2: got no request at 0000000a, expected one"); end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h26;
        @(negedge CLK);
        bus.redirect = 1'b0;
        n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL redir_mem_req_drop: got %b, expected 0", bus.mem_req); end
        n_vec++; if (bus.ins_valid !== 1'b0) begin n_err++; $display("FAIL redir_fifo_empty: got %b, expected 0", bus.ins_valid); end
        @(negedge CLK);
        n_vec++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h24) begin n_err++; $display("FAIL redir_first_addr: got req=%b addr=%h, expected req=1 addr=00000024", bus.mem_req, bus.mem_addr); end
        wait_valid(20, ok);
        n_vec++; if (!ok || bus.ins_pc !== 32'h24) begin n_err++; $display("FAIL redir_ins_pc: got %h (valid=%0b), expected 00000024", bus.ins_pc, ok); end
        n_vec++; if (bus.INSTRUCTION !== 32'h6465_6667) begin n_err++; $display("FAIL redir_word: got %h, expected 64656667", bus.INSTRUCTION); end
    endtask

    task automatic test_wrap();
        bit ok;
        bit found;
        // Continues from test_redirect: head word valid and being popped this cycle.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        @(negedge CLK);
        bus.redirect = 1'b0;
        n_vec++; if (bus.ins_valid !== 1'b0) begin n_err++; $display("FAIL wrap_redirect_beats_pop: got %b, expected 0", bus.ins_valid); end
        wait_valid(20, ok);
        n_vec++; if (!ok || bus.ins_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_top_pc: got %h (valid=%0b), expected fffffffc", bus.ins_pc, ok); end
        n_vec++; if (bus.INSTRUCTION !== 32'h3C3D_3E3F) begin n_err++; $display("FAIL wrap_top_word: got %h, expected 3c3d3e3f", bus.INSTRUCTION); end
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (bus.mem_req === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_vec++; if (!found || bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_next_addr: got %h (req seen=%0b), expected 00000000", bus.mem_addr, found); end
        wait_valid(20, ok);
        n_vec++; if (!ok || bus.ins_pc !== 32'h0) begin n_err++; $display("FAIL wrap_next_pc: got %h (valid=%0b), expected 00000000", bus.ins_pc, ok); end
        n_vec++; if (bus.INSTRUCTION !== 32'h0001_1020) begin n_err++; $display("FAIL wrap_next_word: got %h, expected 00011020", bus.INSTRUCTION); end
    endtask

    task automatic test_reset_mid_word();
        bit ok;
        wait_states   = 0;
        bus.ins_ready = 1'b0;
        apply_reset();
        wait_valid(20, ok);
        repeat (2) @(negedge CLK);
        n_vec++; if (!ok || bus.mem_req !== 1'b1) begin n_err++; $display("FAIL rst_mid_setup: got valid=%0b req=%b, expected valid=1 req=1", ok, bus.mem_req); end
        // Reset must override a simultaneous redirect and pop.
        RESET           = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        bus.ins_ready   = 1'b1;
        @(negedge CLK);
        n_vec++; if (bus.ins_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b, expected 0", bus.ins_valid); end
        n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mid_mem_req: got %b, expected 0", bus.mem_req); end
        RESET        = 1'b0;
        bus.redirect = 1'b0;
        wait_valid(20, ok);
        n_vec++; if (!ok || bus.ins_pc !== 32'h0) begin n_err++; $display("FAIL rst_mid_first_pc: got %h (valid=%0b), expected 00000000", bus.ins_pc, ok); end
        n_vec++; if (bus.INSTRUCTION !== 32'h0001_1020) begin n_err++; $display("FAIL rst_mid_first_word: got %h, expected 00011020", bus.INSTRUCTION); end
    endtask

    initial begin
        bus.ins_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wait_states();
        test_redirect();
        test_wrap();
        test_reset_mid_word();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the number of prefetch FIFO entries (legal range 1..8).
REQ-002 Parameter RESET_PC, default 32'h0, SHALL set the fetch address loaded on reset.
REQ-003 CLK  in  1  sole clock; all state SHALL update on posedge CLK.
REQ-004 RESET  in  1  SHALL be synchronous and active-high.
REQ-005 mem_req  out  1  byte read request to the instruction byte memory.
REQ-006 mem_addr  out  32  byte address of the current request.
REQ-007 mem_ack  in  1  byte returned this cycle; ignored when mem_req=0.
REQ-008 mem_rdata  in  8  returned byte, valid with mem_ack.
REQ-009 ins_valid  out  1  FIFO head holds a complete instruction.
REQ-010 ins_ready  in  1  consumer (instruction register) accepts the head.
REQ-011 INSTRUCTION  out  32  head instruction word.
REQ-012 ins_pc  out  32  byte address of the head instruction.
REQ-013 redirect  in  1  branch/jump taken; flush and refetch.
REQ-014 redirect_pc  in  32  new fetch address, sampled when redirect=1.

Function
REQ-015 States: IDLE (no word in progress) and FETCH (word in progress, byte index 0..3).
REQ-016 IDLE->FETCH when FIFO count < DEPTH; IDLE otherwise.
REQ-017 In FETCH, mem_req SHALL be 1 and mem_addr = fetch_pc + byte index, modulo 2^32.
REQ-018 mem_addr SHALL stay stable while mem_req=1 and mem_ack=0, for any number of wait cycles.
REQ-019 On mem_ack, assemble the word big-endian: index 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
REQ-020 Each mem_ack SHALL advance the byte index by one.
REQ-021 On ack of index 3: push {word, fetch_pc} into the FIFO; fetch_pc += 4 (0xFFFFFFFC wraps to 0); return to IDLE.
REQ-022 The push of REQ-021 SHALL never overflow, because a word is only started with a free slot.
REQ-023 Latency: with first ack at cycle t and acks on t..t+3, ins_valid SHALL be 1 at t+4 for that word (empty FIFO); peak throughput is one word per 4 acked cycles.
REQ-024 ins_valid = (count != 0).
REQ-025 A pop SHALL occur when ins_valid & ins_ready.
REQ-026 Push and pop in the same cycle SHALL both take effect; count unchanged.
REQ-027 INSTRUCTION and ins_pc SHALL read 0 when ins_valid=0.
REQ-028 Redirect SHALL empty the FIFO, discard any partial word and any same-cycle mem_ack, load fetch_pc <= {redirect_pc[31:2],2'b00}, and enter IDLE.
REQ-029 mem_req SHALL be 0 in the cycle after redirect.
REQ-030 Redirect SHALL win over a same-cycle push or pop; ins_valid SHALL be 0 the next cycle.
REQ-031 The FIFO SHALL preserve order; the output pointer wraps modulo DEPTH.

Reset
REQ-032 While RESET=1: fetch_pc <= RESET_PC, FIFO count <= 0, state <= IDLE, byte index <= 0, mem_req=0, ins_valid=0, INSTRUCTION=0, ins_pc=0, mem_addr=0.
REQ-033 RESET SHALL override redirect, ack, and pop.
REQ-034 A word partially assembled when RESET asserts SHALL be discarded.
REQ-035 mem_req SHALL rise no earlier than the first cycle after RESET deasserts.

Verification
REQ-036 Reset, then memory bytes 00,01,10,20 at 0..3 acked every cycle, ins_ready=1 -> INSTRUCTION=32'h00011020, ins_pc=0, ins_valid one cycle, 4 cycles after first ack.
REQ-037 Backpressure: ins_ready=0, DEPTH=2 -> two words (ins_pc 0 and 4) buffered, mem_req=0 with count=2. Raising ins_ready then SHALL pop the head in order and resume fetching at address 8.
REQ-038 Wait states: each mem_ack delayed 3 cycles -> mem_addr constant during each wait; word correct and ins_pc correct.
REQ-039 Redirect after 2 bytes of word at 0x8, redirect_pc=32'h26 -> partial discarded, FIFO empty, next ins_pc=32'h24, bytes fetched from 0x24..0x27.
REQ-040 Redirect_pc=32'hFFFFFFFC -> word at 0xFFFFFFFC delivered, then next mem_addr=0, next ins_pc=0.
REQ-041 RESET asserted mid-word with 1 word buffered -> next cycle ins_valid=0, mem_req=0; after release, first ins_pc=RESET_PC.
